// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and the IO engine.
// Define MEM_ARB_CPU_FIXED_PRIO_EN to make the CPU win every tie (fixed priority).

module mem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              io_rvalid,
    output logic [DATA_W-1:0] io_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    localparam logic [1:0] LP_CNT_LOAD = 2'(RD_LAT - 1);

    state_t            r_state;
    logic              r_sel;          // winner of the access in flight: 0 = CPU, 1 = IO
    logic [1:0]        r_cnt;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_cpu_gnt;
    logic              r_io_gnt;
    logic              r_cpu_rvalid;
    logic              r_io_rvalid;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_io_rdata;
    logic              r_busy;
    logic              w_any_req;
    logic              w_win_io;

    assign w_any_req = cpu_req | io_req;

`ifdef MEM_ARB_CPU_FIXED_PRIO_EN
    assign w_win_io = ~cpu_req;
`else
    logic r_prio;                      // 0 = CPU holds priority, 1 = IO holds priority
    assign w_win_io = (cpu_req & io_req) ? r_prio : io_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_sel        <= 1'b0;
            r_cnt        <= 2'd0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_gnt    <= 1'b0;
            r_io_gnt     <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_io_rvalid  <= 1'b0;
            r_cpu_rdata  <= '0;
            r_io_rdata   <= '0;
            r_busy       <= 1'b0;
`ifndef MEM_ARB_CPU_FIXED_PRIO_EN
            r_prio       <= 1'b0;
`endif
        end else begin
            r_mem_en     <= 1'b0;
            r_cpu_gnt    <= 1'b0;
            r_io_gnt     <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_io_rvalid  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_sel       <= w_win_io;
                        r_mem_we    <= w_win_io ? io_we    : cpu_we;
                        r_mem_addr  <= w_win_io ? io_addr  : cpu_addr;
                        r_mem_wdata <= w_win_io ? io_wdata : cpu_wdata;
                        r_mem_en    <= 1'b1;
                        r_cpu_gnt   <= ~w_win_io;
                        r_io_gnt    <= w_win_io;
                        r_busy      <= 1'b1;
`ifndef MEM_ARB_CPU_FIXED_PRIO_EN
                        r_prio      <= ~w_win_io;
`endif
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_mem_we <= 1'b0;
                    if (r_mem_we) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= LP_CNT_LOAD;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Final wait cycle: memory data is valid now, present it next cycle.
                    if (r_cnt == 2'd0) begin
                        if (r_sel) begin
                            r_io_rdata  <= mem_rdata;
                            r_io_rvalid <= 1'b1;
                        end else begin
                            r_cpu_rdata  <= mem_rdata;
                            r_cpu_rvalid <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_gnt    = r_cpu_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign io_gnt     = r_io_gnt;
    assign io_rvalid  = r_io_rvalid;
    assign io_rdata   = r_io_rdata;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random CPU/IO traffic against a transaction-level model.
// Honours MEM_ARB_CPU_FIXED_PRIO_EN when the design is built with it.

module tb_mem_arbiter;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int RD_LAT = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              io_req = 1'b0, io_we = 1'b0;
    logic [ADDR_W-1:0] io_addr = '0;
    logic [DATA_W-1:0] io_wdata = '0;
    logic              cpu_gnt, cpu_rvalid, io_gnt, io_rvalid;
    logic [DATA_W-1:0] cpu_rdata, io_rdata;
    logic              mem_en, mem_we, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return DATA_W'(i * 4951 + 48879);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Block RAM model: 16 words, read data appears RD_LAT cycles after mem_en, junk otherwise.
    logic [DATA_W-1:0] ram    [16];
    logic [DATA_W-1:0] pipe_d [RD_LAT];
    logic              pipe_v [RD_LAT];
    logic [DATA_W-1:0] junk;

    always @(posedge clk) begin
        junk <= DATA_W'($urandom);
        if (reset) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
        end else if (mem_en && mem_we) begin
            ram[mem_addr[3:0]] <= mem_wdata;
        end
        pipe_v[0] <= mem_en && !mem_we;
        pipe_d[0] <= ram[mem_addr[3:0]];
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    assign mem_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : junk;

    // Reference model state
    typedef struct { logic [DATA_W-1:0] d; int due; } rd_t;
    rd_t               q_cpu[$];
    rd_t               q_io[$];
    logic [DATA_W-1:0] ref_mem [16];
    logic [DATA_W-1:0] last_rd [2];
    int                free_cyc = 0;
    bit                arb_pend = 1'b0;
    bit                exp_win = 1'b0;
    bit                m_prio = 1'b0;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;

    initial begin : monitor
        rd_t e;
        bit  exp_rv;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                q_cpu.delete();
                q_io.delete();
                arb_pend   = 1'b0;
                free_cyc   = 0;
                m_prio     = 1'b0;
                last_rd[0] = '0;
                last_rd[1] = '0;
                for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
            end else begin
                chk("gnt", {io_gnt, cpu_gnt}, !arb_pend ? 2'b00 : (exp_win ? 2'b10 : 2'b01));
                chk("mem_en", mem_en, arb_pend);
                if (arb_pend) begin
                    chk("mem_we", mem_we, exp_we);
                    chk("mem_addr", mem_addr, exp_addr);
                    if (exp_we) begin
                        chk("mem_wdata", mem_wdata, exp_wdata);
                        ref_mem[exp_addr[3:0]] = exp_wdata;
                        free_cyc = cyc + 1;
                    end else begin
                        e.d   = ref_mem[exp_addr[3:0]];
                        e.due = cyc + RD_LAT + 1;
                        if (exp_win) q_io.push_back(e);
                        else         q_cpu.push_back(e);
                        free_cyc = cyc + RD_LAT + 1;
                    end
                    m_prio = !exp_win;
                end else if (cyc < free_cyc) begin
                    chk("mem_we_wait", mem_we, 1'b0);
                end
                chk("busy", busy, cyc < free_cyc);

                exp_rv = (q_cpu.size() > 0) && (q_cpu[0].due == cyc);
                chk("cpu_rvalid", cpu_rvalid, exp_rv);
                if (exp_rv) begin
                    e = q_cpu.pop_front();
                    last_rd[0] = e.d;
                end
                chk("cpu_rdata", cpu_rdata, last_rd[0]);

                exp_rv = (q_io.size() > 0) && (q_io[0].due == cyc);
                chk("io_rvalid", io_rvalid, exp_rv);
                if (exp_rv) begin
                    e = q_io.pop_front();
                    last_rd[1] = e.d;
                end
                chk("io_rdata", io_rdata, last_rd[1]);

                arb_pend = (cyc >= free_cyc) && (cpu_req || io_req);
                if (arb_pend) begin
`ifdef MEM_ARB_CPU_FIXED_PRIO_EN
                    exp_win = !cpu_req;
`else
                    exp_win = (cpu_req && io_req) ? m_prio : io_req;
`endif
                    exp_we    = exp_win ? io_we    : cpu_we;
                    exp_addr  = exp_win ? io_addr  : cpu_addr;
                    exp_wdata = exp_win ? io_wdata : cpu_wdata;
                end
            end
        end
    end

    function automatic logic gnt_of(input int id);
        return (id != 0) ? io_gnt : cpu_gnt;
    endfunction

    task automatic set_req(input int id, input logic rq, input logic w,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (id == 0) begin
            cpu_req = rq; cpu_we = w; cpu_addr = a; cpu_wdata = d;
        end else begin
            io_req = rq; io_we = w; io_addr = a; io_wdata = d;
        end
    endtask

    // Requester: issues n transactions, holding req until gnt, then an optional gap.
    task automatic agent(input int id, input int n, input bit burst);
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int                gap;
        int                waited;
        for (int k = 0; k < n; k++) begin
            w   = burst ? 1'b1 : 1'($urandom_range(0, 1));
            a   = ADDR_W'($urandom_range(0, 15));
            d   = DATA_W'($urandom);
            gap = burst ? 0 : int'($urandom_range(0, 3)) - 1;
            if (gap < 0) gap = 0;
            set_req(id, 1'b1, w, a, d);
            waited = 0;
            do begin
                @(posedge clk); #1;
                waited++;
            end while (!gnt_of(id) && waited < 100);
            chk((id != 0) ? "io_gnt_wait" : "cpu_gnt_wait", gnt_of(id), 1'b1);
            set_req(id, 1'b0, w, a, d);
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   waited;
        bit   seen_first;
        logic [1:0] done;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, mem_en, mem_we, busy}, 7'd0);
        chk("rst_mem_bus", {mem_addr, mem_wdata}, 32'd0);
        chk("rst_rdata", {cpu_rdata, io_rdata}, 32'd0);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        agent(0, 10, 1'b0);
        agent(1, 10, 1'b0);
        fork
            agent(0, 8, 1'b1);
            agent(1, 8, 1'b1);
        join
        fork
            agent(0, 70, 1'b0);
            agent(1, 70, 1'b0);
        join
        repeat (RD_LAT + 6) @(posedge clk);
        #1;

        // Reset in the middle of a CPU read's wait phase
        set_req(0, 1'b1, 1'b0, ADDR_W'(5), '0);
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!cpu_gnt && waited < 20);
        chk("rstwait_cpu_gnt", cpu_gnt, 1'b1);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("rstwait_busy", busy, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("rstwait_ctrl", {cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, mem_en, mem_we, busy}, 7'd0);
        chk("rstwait_mem_bus", {mem_addr, mem_wdata}, 32'd0);
        chk("rstwait_rdata", {cpu_rdata, io_rdata}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (RD_LAT + 4) @(posedge clk);
        #1;

        // First tie after reset goes to the CPU
        set_req(0, 1'b1, 1'b0, ADDR_W'(3), '0);
        set_req(1, 1'b1, 1'b0, ADDR_W'(9), '0);
        seen_first = 1'b0;
        done = 2'b00;
        waited = 0;
        while (done != 2'b11 && waited < 60) begin
            @(posedge clk); #1;
            waited++;
            if (!seen_first && (cpu_gnt || io_gnt)) begin
                chk("tie_after_reset", {io_gnt, cpu_gnt}, 2'b01);
                seen_first = 1'b1;
            end
            if (cpu_gnt) begin cpu_req = 1'b0; done[0] = 1'b1; end
            if (io_gnt)  begin io_req  = 1'b0; done[1] = 1'b1; end
        end
        chk("tie_both_served", done, 2'b11);
        repeat (RD_LAT + 6) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port program/data memory between two requesters: the CPU (fetch, LOAD, STOR) and the IO/display engine.
- Sits between the control FSM/datapath memory interface and the block RAM.
- Sequences each access with registered memory-side signals, returns read data after the configured latency, and arbitrates round-robin.

Parameters:
DATA_W, 16, data bus width
ADDR_W, 16, address bus width
RD_LAT, 1, memory read latency in cycles; legal range 1..3

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU access request; held until cpu_gnt
cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_gnt  output  1  one-cycle pulse when the CPU access is issued
cpu_rvalid  output  1  one-cycle pulse; cpu_rdata is valid
cpu_rdata  output  DATA_W  CPU read data, held until the next CPU read completes
io_req, io_we, io_addr, io_wdata  input  1/1/ADDR_W/DATA_W  same as the CPU set, for IO
io_gnt, io_rvalid  output  1  same as the CPU set, for IO
io_rdata  output  DATA_W  same as the CPU set, for IO
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid RD_LAT cycles after mem_en
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, any state):
  - Go to IDLE.
  - All outputs go to 0, including rdata registers.
  - prio is set to CPU.
  - An in-flight read is discarded; no rvalid is produced after release.
- States: IDLE, ISSUE, WAIT. All outputs are registered.
- IDLE:
  - If either req is high, select the winner.
  - Latch the winner's we/addr/wdata into mem_we/mem_addr/mem_wdata. Go to ISSUE.
  - If no req is high, stay in IDLE with mem_en=0.
- ISSUE (exactly 1 cycle):
  - mem_en=1; the winner's gnt=1.
  - Write: next state is IDLE.
  - Read: load a 2-bit counter with RD_LAT-1 and go to WAIT.
- WAIT:
  - Lasts RD_LAT cycles. mem_en=0, mem_we=0.
  - On the final cycle, capture mem_rdata into the winner's rdata register.
  - Next cycle: winner's rvalid=1 and state returns to IDLE.
- Timing, with req first seen in IDLE at cycle 0:
  - gnt at cycle 1.
  - Read rvalid at cycle RD_LAT+2.
  - Write: busy drops at cycle 2.
- Back-to-back: a new request is arbitrated in the same cycle that rvalid pulses. There are no idle bubbles beyond IDLE itself.
- Arbitration (round-robin, 1-bit prio register):
  - Both requesting: the prio holder wins.
  - Only one requesting: it wins.
  - After every grant, prio points to the non-winner.
- Requester rules:
  - Deassert req in the cycle after gnt; a req still high in that cycle is a new request.
  - Fields must be stable from req rise until gnt.
- Never: both gnt high together, both rvalid high together, or mem_en high outside ISSUE.
- rvalid never pulses for writes.
- rdata of the non-winner is unchanged.

Optional Feature:
MEM_ARB_CPU_FIXED_PRIO_EN
- Defined: fixed priority. The CPU wins every tie, so IO is granted only when cpu_req is low in IDLE. prio is unused.
- Undefined: round-robin as specified above.

Test Plan:
- CPU read alone, addr 0x0010, memory returns 0xBEEF, RD_LAT=1 -> cycle 1: cpu_gnt=1, mem_en=1, mem_we=0, mem_addr=0x0010; cycle 3: cpu_rvalid=1, cpu_rdata=0xBEEF; io_rvalid stays 0.
- IO write, addr 0x2000, data 0x1234 -> cycle 1: io_gnt=1, mem_en=1, mem_we=1, mem_wdata=0x1234; no rvalid; busy=0 at cycle 2.
- Both reads raised at cycle 0 after reset, RD_LAT=1 -> cpu_gnt cycle 1, cpu_rvalid cycle 3, io_gnt cycle 4, io_rvalid cycle 6.
- Both continuously requesting writes (req re-raised after each gnt) -> grants alternate CPU, IO, CPU, IO at cycles 1, 3, 5, 7. With MEM_ARB_CPU_FIXED_PRIO_EN: all grants go to the CPU.
- reset pulsed during WAIT of a CPU read -> all outputs 0 immediately; no cpu_rvalid after release; next tie is granted to the CPU.
- RD_LAT=3, CPU read -> cpu_gnt cycle 1, mem_en low for cycles 2-4, cpu_rvalid cycle 5 carrying mem_rdata sampled in cycle 4.
